// File: rtl/uart_tx_arbiter_if.sv
// Producer/transmitter-side signal bundle for uart_tx_arbiter.
// master = producer/test side, slave = arbiter.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int GRANT_W = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic [7:0]         tx_data;
  logic               tx_send;
  logic [GRANT_W-1:0] grant_id;
  logic               busy;
  logic               frame_done;

  modport master (
    output req_valid, req_data,
    input  req_ready, tx_data, tx_send, grant_id, busy, frame_done
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, tx_data, tx_send, grant_id, busy, frame_done
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between N_REQ byte producers.
// The transmitter has no done flag, so frame length is timed locally.
//
// state | meaning
// IDLE  | arbitrate; winner gets req_ready and its byte is latched
// SEND  | one-cycle tx_send pulse to the transmitter
// WAIT  | time the frame plus guard; frame_done in the final cycle
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int COUNTS_PER_BIT = 434,
  parameter int GUARD_CYCLES   = 2
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus
);
  localparam int GRANT_W      = $clog2(N_REQ);
  localparam int FRAME_CYCLES = 11*COUNTS_PER_BIT + 1 + GUARD_CYCLES;
  localparam int TIMER_W      = $clog2(FRAME_CYCLES) + 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(FRAME_CYCLES - 2);
  localparam logic [GRANT_W:0]   N_REQ_W    = (GRANT_W+1)'(N_REQ);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t             state, state_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic [7:0]         tx_data_q, tx_data_nxt;
  logic [GRANT_W-1:0] grant_q, grant_nxt;
  logic [GRANT_W-1:0] last_grant, last_grant_nxt;
  logic [GRANT_W-1:0] winner;
  logic               winner_found;
  logic [GRANT_W:0]   cand;
  logic [7:0]         winner_data;
  logic [N_REQ-1:0]   ready_c;
  logic               frame_done_c;

  // Search starts just past the previous owner, so it always ranks last.
  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    cand         = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = {1'b0, last_grant} + (GRANT_W+1)'(i);
      if (cand >= N_REQ_W) cand = cand - N_REQ_W;
      if (!winner_found && bus.req_valid[cand[GRANT_W-1:0]]) begin
        winner_found = 1'b1;
        winner       = cand[GRANT_W-1:0];
      end
    end
  end

  // Only the winner's lane is selected, keeping other lanes' X off tx_data.
  always_comb begin
    winner_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == GRANT_W'(i)) winner_data = bus.req_data[8*i +: 8];
    end
  end

  always_comb begin
    state_nxt      = state;
    timer_nxt      = timer;
    tx_data_nxt    = tx_data_q;
    grant_nxt      = grant_q;
    last_grant_nxt = last_grant;
    ready_c        = '0;
    frame_done_c   = 1'b0;
    case (state)
      IDLE: begin
        if (winner_found && rst) begin
          ready_c     = {{(N_REQ-1){1'b0}}, 1'b1} << winner;
          tx_data_nxt = winner_data;
          grant_nxt   = winner;
          state_nxt   = SEND;
        end
      end
      SEND: begin
        timer_nxt = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        timer_nxt = timer + 1'b1;
        if (timer == TIMER_LAST) begin
          frame_done_c   = 1'b1;
          last_grant_nxt = grant_q;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      timer      <= '0;
      tx_data_q  <= '0;
      grant_q    <= '0;
      last_grant <= GRANT_W'(N_REQ - 1);
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      tx_data_q  <= tx_data_nxt;
      grant_q    <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  assign bus.req_ready  = ready_c;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_send    = (state == SEND);
  assign bus.grant_id   = grant_q;
  assign bus.busy       = (state != IDLE);
  assign bus.frame_done = frame_done_c;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: frame-level reference model, behavioural UART
// transmitter and serial decoder, directed scenarios plus random traffic.
module tb_uart_tx_arbiter;
  localparam int N     = 4;
  localparam int CPB   = 4;
  localparam int GUARD = 2;
  localparam int FC    = 11*CPB + 1 + GUARD;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();
  uart_tx_arbiter #(.N_REQ(N), .COUNTS_PER_BIT(CPB), .GUARD_CYCLES(GUARD)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // stimulus state
  logic [N-1:0] pend;
  logic [7:0]   pbyte [N];
  logic         refill, rnd, x_noise, mon_en;
  logic [N-1:0] acc_now;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = pend[i];
      bus.req_data[8*i +: 8] = pend[i] ? pbyte[i] : (x_noise ? 8'hxx : 8'($urandom));
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (acc_now[i] && !refill) pend[i] = 1'b0;
      if (rnd) begin
        if (!pend[i] && $urandom_range(0, 7) == 0) begin
          pend[i] = 1'b1;
          pbyte[i] = 8'($urandom);
        end else if (pend[i] && $urandom_range(0, 63) == 0) pend[i] = 1'b0;
      end
    end
    if (rnd) x_noise = 1'($urandom_range(0, 1));
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  // behavioural transmitter: one pickup cycle, then start, 8 data LSB-first, even parity, stop
  int   tx_t = 0;
  int   bit_i;
  logic serial_out;

  always @(posedge clk) begin
    if (!rst) tx_t <= 0;
    else if (bus.tx_send) tx_t <= 1;
    else if (tx_t != 0 && tx_t < 11*CPB + 1) tx_t <= tx_t + 1;
    else tx_t <= 0;
  end

  always_comb begin
    bit_i = 0;
    serial_out = 1'b1;
    if (tx_t >= 2) begin
      bit_i = (tx_t - 2) / CPB;
      if (bit_i == 0) serial_out = 1'b0;
      else if (bit_i <= 8) serial_out = bus.tx_data[bit_i-1];
      else if (bit_i == 9) serial_out = ^bus.tx_data;
    end
  end

  // reference model: a grant at cycle g puts tx_send at g+1, frame_done at g+FC, idle at g+FC+1
  int         mcyc = 0, m_gstart = 0, m_last = N-1, m_gid = 0, k = 0, win = -1, idx = 0;
  logic       m_active = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic [N-1:0] e_ready;
  int         exp_q [$];
  int         glog [$];
  int         dlog [$];
  int         n_send = 0, n_done = 0, n_busy = 0, last_send = -1;
  logic       d_active = 1'b0;
  int         d_ph = 0, d_k = 0;
  logic [7:0] d_byte = 8'h00;
  logic       d_par = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      mcyc++;
      e_ready = '0;
      win = -1;
      k = 0;
      if (m_active) k = mcyc - m_gstart;
      else if (rst) begin
        for (int j = 1; j <= N; j++) begin
          idx = (m_last + j) % N;
          if (win < 0 && bus.req_valid[idx]) win = idx;
        end
        if (win >= 0) e_ready[win] = 1'b1;
      end
      chk("req_ready",  bus.req_ready,  e_ready);
      chk("tx_send",    bus.tx_send,    m_active && k == 1);
      chk("frame_done", bus.frame_done, m_active && k == FC);
      chk("busy",       bus.busy,       m_active && k >= 1);
      chk("tx_data",    bus.tx_data,    m_data);
      chk("grant_id",   bus.grant_id,   m_gid);
      acc_now = bus.req_valid & bus.req_ready;
      if (bus.tx_send === 1'b1) begin
        n_send++;
        glog.push_back(int'(bus.grant_id));
        if (last_send >= 0) chk("send_spacing", (mcyc - last_send) >= FC + 1, 1);
        last_send = mcyc;
      end
      if (bus.frame_done === 1'b1) n_done++;
      if (bus.busy === 1'b1) n_busy++;

      // serial decoder, sampling mid-bit
      if (rst) begin
        if (!d_active) begin
          if (serial_out == 1'b0) begin
            d_active = 1'b1;
            d_ph = 0;
          end
        end else begin
          d_ph++;
          if (d_ph % CPB == CPB/2) begin
            d_k = d_ph / CPB;
            if (d_k >= 1 && d_k <= 8) d_byte[d_k-1] = serial_out;
            else if (d_k == 9) d_par = serial_out;
            else if (d_k == 10) begin
              d_active = 1'b0;
              chk("uart_stop", serial_out, 1'b1);
              chk("uart_parity", d_par, ^d_byte);
              dlog.push_back(int'(d_byte));
              chk("uart_expected", exp_q.size() > 0, 1);
              if (exp_q.size() > 0) chk("uart_byte", d_byte, exp_q.pop_front());
            end
          end
        end
      end

      if (!rst) begin
        m_active = 1'b0; m_last = N-1; m_gid = 0; m_data = 8'h00;
        exp_q.delete(); last_send = -1; d_active = 1'b0;
      end else if (m_active && k == FC) begin
        m_active = 1'b0;
        m_last = m_gid;
      end else if (!m_active && win >= 0) begin
        m_active = 1'b1;
        m_gstart = mcyc;
        m_gid = win;
        m_data = bus.req_data[8*win +: 8];
        exp_q.push_back(int'(m_data));
      end
    end
  end

  int exp_seq [$];
  task automatic check_seq(input string tag, input int got [$]);
    chk({tag, "_len"}, got.size(), exp_seq.size());
    foreach (exp_seq[j]) if (j < got.size()) chk(tag, got[j], exp_seq[j]);
  endtask

  int base_send, base_done, base_busy;
  logic [7:0] b0;

  initial begin
    mon_en = 1'b0; refill = 1'b0; rnd = 1'b0; x_noise = 1'b1;
    pend = '0; acc_now = '0;
    for (int i = 0; i < N; i++) pbyte[i] = 8'h00;
    drive();
    @(posedge clk); #1;
    mon_en = 1'b1;
    step();
    rst = 1'b1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    chk("rst_grant", bus.grant_id, 0);
    chk("rst_send", bus.tx_send, 0);

    // single request from requester 2
    glog.delete(); dlog.delete(); base_done = n_done;
    pend[2] = 1'b1; pbyte[2] = 8'hA5; drive();
    step();
    chk("single_send_c1", bus.tx_send, 1);
    step();
    chk("single_send_c2", bus.tx_send, 0);
    repeat (44) step();
    step();
    chk("single_done_c47", bus.frame_done, 1);
    step();
    chk("single_idle_c48", bus.busy, 0);
    repeat (5) step();
    exp_seq.delete(); exp_seq.push_back(2); check_seq("single_grant", glog);
    exp_seq.delete(); exp_seq.push_back(8'hA5); check_seq("single_byte", dlog);
    chk("single_done_cnt", n_done - base_done, 1);

    // all four requesting continuously
    do_reset();
    glog.delete(); dlog.delete();
    refill = 1'b1;
    for (int i = 0; i < N; i++) begin pend[i] = 1'b1; pbyte[i] = 8'(8'h10 + i); end
    drive();
    repeat (200) step();
    pend = '0; refill = 1'b0; drive();
    repeat (60) step();
    exp_seq.delete();
    exp_seq.push_back(0); exp_seq.push_back(1); exp_seq.push_back(2); exp_seq.push_back(3); exp_seq.push_back(0);
    check_seq("all4_grant", glog);
    exp_seq.delete();
    exp_seq.push_back(8'h10); exp_seq.push_back(8'h11); exp_seq.push_back(8'h12); exp_seq.push_back(8'h13); exp_seq.push_back(8'h10);
    check_seq("all4_byte", dlog);

    // rotation between 1 and 3, then 0 arriving mid-frame
    do_reset();
    glog.delete(); dlog.delete();
    refill = 1'b1;
    pend[1] = 1'b1; pbyte[1] = 8'h31; drive();
    repeat (5) step();
    pend[3] = 1'b1; pbyte[3] = 8'h33; drive();
    repeat (145) step();
    pend[0] = 1'b1; pbyte[0] = 8'h30; drive();
    repeat (100) step();
    pend = '0; refill = 1'b0; drive();
    repeat (60) step();
    exp_seq.delete();
    exp_seq.push_back(1); exp_seq.push_back(3); exp_seq.push_back(1);
    exp_seq.push_back(3); exp_seq.push_back(0); exp_seq.push_back(1);
    check_seq("rot_grant", glog);

    // reset in the middle of a frame
    do_reset();
    glog.delete(); dlog.delete(); base_done = n_done;
    pend[2] = 1'b1; pbyte[2] = 8'($urandom); drive();
    step();
    repeat (19) step();
    rst = 1'b0;
    step();
    chk("midrst_send", bus.tx_send, 0);
    chk("midrst_data", bus.tx_data, 8'h00);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_ready", bus.req_ready, 0);
    rst = 1'b1;
    b0 = 8'($urandom);
    pend[0] = 1'b1; pbyte[0] = b0; pend[3] = 1'b1; pbyte[3] = 8'h5A; drive();
    #3;
    chk("midrst_first_ready", bus.req_ready, 4'b0001);
    step();
    chk("midrst_first_grant", bus.grant_id, 0);
    pend = '0; drive();
    repeat (60) step();
    chk("midrst_done_cnt", n_done - base_done, 1);
    exp_seq.delete(); exp_seq.push_back(int'(b0)); check_seq("midrst_byte", dlog);

    // randomized traffic
    do_reset();
    base_send = n_send;
    rnd = 1'b1;
    repeat (2500) step();
    rnd = 1'b0; x_noise = 1'b1; pend = '0; drive();
    repeat (60) step();
    chk("rnd_progress", (n_send - base_send) > 20, 1);

    // idle period
    base_send = n_send; base_done = n_done; base_busy = n_busy;
    repeat (200) step();
    chk("idle_send", n_send - base_send, 0);
    chk("idle_done", n_done - base_done, 0);
    chk("idle_busy", n_busy - base_busy, 0);
    chk("idle_tx_data", bus.tx_data, m_data);
    chk("uart_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
